// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin request arbiter.
// Holds FSM state codes, default sizing and the seven-segment glyph table.
package arb_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam int N_DEF       = 8;
    localparam int TIMEOUT_DEF = 16;

    // Active-high segments, bit order {dp,g,f,e,d,c,b,a}
    function automatic logic [7:0] seg7(input logic [3:0] v);
        logic [7:0] p;
        p = 8'h00;
        unique case (v)
            4'h0: p = 8'h3F;
            4'h1: p = 8'h06;
            4'h2: p = 8'h5B;
            4'h3: p = 8'h4F;
            4'h4: p = 8'h66;
            4'h5: p = 8'h6D;
            4'h6: p = 8'h7D;
            4'h7: p = 8'h07;
            4'h8: p = 8'h7F;
            4'h9: p = 8'h6F;
            4'hA: p = 8'h77;
            4'hB: p = 8'h7C;
            4'hC: p = 8'h39;
            4'hD: p = 8'h5E;
            4'hE: p = 8'h79;
            4'hF: p = 8'h71;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rr_req_arbiter_if.sv
// Requester/arbiter bundle: req/done handshake, grant status and display.
// master = requester side, slave = arbiter side.
interface rr_req_arbiter_if #(
    parameter int N   = 8,
    parameter int IDW = 3
);

    logic                 en;
    logic [N-1:0]         req;
    logic [N-1:0]         done;
    logic [N-1:0]         gnt;
    logic                 gnt_valid;
    logic [IDW-1:0]       gnt_id;
    logic                 timeout_pulse;
    logic [7:0]           grant_cnt;
    logic [7:0][7:0]      seg_out;

    modport master (
        output en,
        output req,
        output done,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  timeout_pulse,
        input  grant_cnt,
        input  seg_out
    );

    modport slave (
        input  en,
        input  req,
        input  done,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output timeout_pulse,
        output grant_cnt,
        output seg_out
    );

endinterface

// File: rtl/rr_pick.sv
// Rotated priority scan: first set request at ptr, ptr+1, ... mod N.
// Covers all N positions, so a lone request just behind ptr is still found.
module rr_pick #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] pick_o,
    output logic           any_o
);

    logic [IDW-1:0] idx;

    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDW'((int'(ptr_i) + i) % N);
            if (!any_o && req_i[idx]) begin
                any_o  = 1'b1;
                pick_o = idx;
            end
        end
    end

endmodule

// File: rtl/seg.sv
// Seven-segment digit decoder with blanking enable.
module seg
    import arb_pkg::*;
(
    input  logic [3:0] in_i,
    input  logic       en_i,
    output logic [7:0] out_o
);

    assign out_o = en_i ? seg7(in_i) : 8'h00;

endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter with req/done handshake, optional hold timeout,
// and a seven-segment readout of the owner id and running grant count.
module rr_req_arbiter
    import arb_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int IDW     = $clog2(N),
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic            clk,
    input logic            rst,
    rr_req_arbiter_if.slave bus
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic           state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           to_q, to_d;

    logic [IDW-1:0] pick;
    logic           any;
    logic           own_done;
    logic           own_req;
    logic           to_hit;
    logic           rel;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i  (bus.req),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .any_o  (any)
    );

    assign own_done = bus.done[gnt_id_q];
    assign own_req  = bus.req[gnt_id_q];
    assign to_hit   = (TIMEOUT != 0) && (timer_q == TMAX);
    assign rel      = own_done | ~own_req | to_hit;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        to_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    gnt_d    = N'(1) << pick;
                    gnt_id_d = pick;
                    cnt_d    = cnt_q + 8'd1;
                    timer_d  = '0;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (rel) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                    ptr_d   = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
                    // Pulse only when the timer alone forced the release
                    to_d    = to_hit & own_req & ~own_done;
                end else if (TIMEOUT != 0 && timer_q != TMAX) begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= '0;
            timer_q  <= '0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
        end
    end

    logic [7:0][3:0] dig_in;
    logic [7:0]      dig_en;
    logic [7:0][7:0] seg_w;

    // Digits 3..7 are fitted but always blank
    always_comb begin
        dig_in    = '0;
        dig_en    = '0;
        dig_in[0] = 4'(gnt_id_q);
        dig_en[0] = bus.en & (|gnt_q);
        dig_in[1] = cnt_q[3:0];
        dig_en[1] = bus.en;
        dig_in[2] = cnt_q[7:4];
        dig_en[2] = bus.en;
    end

    for (genvar g = 0; g < 8; g++) begin : g_dig
        seg u_seg (
            .in_i  (dig_in[g]),
            .en_i  (dig_en[g]),
            .out_o (seg_w[g])
        );
    end

    assign bus.gnt           = gnt_q;
    assign bus.gnt_valid     = |gnt_q;
    assign bus.gnt_id        = gnt_id_q;
    assign bus.timeout_pulse = to_q;
    assign bus.grant_cnt     = cnt_q;
    assign bus.seg_out       = seg_w;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter: three instances (TIMEOUT 4, 16, 0) on shared stimulus.
module tb_rr_req_arbiter;

    localparam int N = 8;
    localparam int K = 3;
    localparam int TOV [K] = '{4, 16, 0};
    localparam logic [7:0] SEGT [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] done = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_req_arbiter_if #(.N(8), .IDW(3)) if4 ();
    rr_req_arbiter_if #(.N(8), .IDW(3)) if16 ();
    rr_req_arbiter_if #(.N(8), .IDW(3)) if0 ();

    assign if4.en = en;   assign if4.req = req;   assign if4.done = done;
    assign if16.en = en;  assign if16.req = req;  assign if16.done = done;
    assign if0.en = en;   assign if0.req = req;   assign if0.done = done;

    rr_req_arbiter #(.N(8), .IDW(3), .TIMEOUT(4))  u_t4  (.clk(clk), .rst(rst), .bus(if4));
    rr_req_arbiter #(.N(8), .IDW(3), .TIMEOUT(16)) u_t16 (.clk(clk), .rst(rst), .bus(if16));
    rr_req_arbiter #(.N(8), .IDW(3), .TIMEOUT(0))  u_t0  (.clk(clk), .rst(rst), .bus(if0));

    logic [7:0]  o_gnt [K];
    logic        o_val [K];
    logic [2:0]  o_id  [K];
    logic        o_to  [K];
    logic [7:0]  o_cnt [K];
    logic [63:0] o_seg [K];

    assign o_gnt[0] = if4.gnt;  assign o_gnt[1] = if16.gnt;  assign o_gnt[2] = if0.gnt;
    assign o_val[0] = if4.gnt_valid;  assign o_val[1] = if16.gnt_valid;
    assign o_val[2] = if0.gnt_valid;
    assign o_id[0] = if4.gnt_id;  assign o_id[1] = if16.gnt_id;  assign o_id[2] = if0.gnt_id;
    assign o_to[0] = if4.timeout_pulse;  assign o_to[1] = if16.timeout_pulse;
    assign o_to[2] = if0.timeout_pulse;
    assign o_cnt[0] = if4.grant_cnt;  assign o_cnt[1] = if16.grant_cnt;
    assign o_cnt[2] = if0.grant_cnt;
    assign o_seg[0] = if4.seg_out;  assign o_seg[1] = if16.seg_out;  assign o_seg[2] = if0.seg_out;

    // Reference model: owner (-1 = none), cycles held, scan start, grants issued
    int m_owner [K];
    int m_id    [K];
    int m_held  [K];
    int m_ptr   [K];
    int m_cnt   [K];
    bit m_pulse [K];

    task automatic model_step(input int k);
        int o;
        bit timed;
        m_pulse[k] = 1'b0;
        if (m_owner[k] < 0) begin
            for (int j = 0; j < N; j++) begin
                int c;
                c = (m_ptr[k] + j) % N;
                if (m_owner[k] < 0 && req[c]) begin
                    m_owner[k] = c;
                    m_id[k] = c;
                    m_held[k] = 1;
                    m_cnt[k] = (m_cnt[k] + 1) % 256;
                end
            end
        end else begin
            o = m_owner[k];
            timed = (TOV[k] != 0) && (m_held[k] == TOV[k]);
            if (done[o] || !req[o] || timed) begin
                m_pulse[k] = timed && !done[o] && req[o];
                m_ptr[k] = (o + 1) % N;
                m_owner[k] = -1;
            end else begin
                m_held[k] = m_held[k] + 1;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < K; k++) begin
                m_owner[k] = -1; m_id[k] = 0; m_held[k] = 0;
                m_ptr[k] = 0; m_cnt[k] = 0; m_pulse[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < K; k++) model_step(k);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_seg(input int k);
        logic [7:0][7:0] s;
        logic [7:0] c;
        s = '0;
        c = 8'(m_cnt[k]);
        if (en && m_owner[k] >= 0) s[0] = SEGT[m_id[k]];
        if (en) begin
            s[1] = SEGT[c[3:0]];
            s[2] = SEGT[c[7:4]];
        end
        return s;
    endfunction

    task automatic check_all();
        for (int k = 0; k < K; k++) begin
            logic [7:0] eg;
            eg = (m_owner[k] < 0) ? 8'h00 : 8'(1 << m_owner[k]);
            chk($sformatf("m%0d_gnt", k), 64'(o_gnt[k]), 64'(eg));
            chk($sformatf("m%0d_val", k), 64'(o_val[k]), 64'(m_owner[k] >= 0));
            chk($sformatf("m%0d_id", k), 64'(o_id[k]), 64'(m_id[k]));
            chk($sformatf("m%0d_to", k), 64'(o_to[k]), 64'(m_pulse[k]));
            chk($sformatf("m%0d_cnt", k), 64'(o_cnt[k]), 64'(m_cnt[k]));
            chk($sformatf("m%0d_seg", k), o_seg[k], exp_seg(k));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        int prev;
        int n;
        #2;
        do_reset();
        chk("rst_gnt", 64'(if4.gnt), 64'h0);
        chk("rst_val", 64'(if4.gnt_valid), 64'h0);
        chk("rst_id", 64'(if4.gnt_id), 64'h0);
        chk("rst_cnt", 64'(if4.grant_cnt), 64'h0);
        chk("rst_to", 64'(if4.timeout_pulse), 64'h0);

        req = 8'b0010_0100;
        step(1);
        chk("t1_gnt", 64'(if4.gnt), 64'h04);
        chk("t1_id", 64'(if4.gnt_id), 64'd2);
        chk("t1_cnt", 64'(if4.grant_cnt), 64'd1);
        chk("t1_seg0", 64'(if4.seg_out[0]), 64'h5B);

        done = 8'h04;
        step(1);
        done = 8'h00;
        chk("t2_bubble", 64'(if4.gnt), 64'h0);
        step(1);
        chk("t2_gnt", 64'(if4.gnt), 64'h20);
        chk("t2_id", 64'(if4.gnt_id), 64'd5);
        req = 8'h00;
        step(2);

        do_reset();
        req = 8'hFF;
        prev = -1;
        for (int g = 0; g < 9; g++) begin
            n = 0;
            while (if4.gnt_valid !== 1'b1 && n < 6) begin
                step(1);
                n++;
            end
            chk("t3_wait", 64'(if4.gnt_valid), 64'h1);
            chk("t3_id", 64'(if4.gnt_id), 64'(g % 8));
            chk("t3_nodup", 64'(int'(if4.gnt_id) != prev), 64'h1);
            prev = int'(if4.gnt_id);
            done = 8'(1 << (g % 8));
            step(1);
            done = 8'h00;
        end
        req = 8'h00;
        step(2);

        do_reset();
        req = 8'h09;
        step(1);
        chk("t4_gnt0", 64'(if4.gnt), 64'h01);
        for (int i = 1; i < 4; i++) begin
            step(1);
            chk("t4_hold", 64'(if4.gnt), 64'h01);
        end
        step(1);
        chk("t4_rel", 64'(if4.gnt), 64'h00);
        chk("t4_pulse", 64'(if4.timeout_pulse), 64'h1);
        step(1);
        chk("t4_next", 64'(if4.gnt), 64'h08);
        chk("t4_id", 64'(if4.gnt_id), 64'd3);
        chk("t4_pulse_off", 64'(if4.timeout_pulse), 64'h0);

        done = 8'h40;
        step(1);
        done = 8'h00;
        chk("t5_ign", 64'(if4.gnt), 64'h08);
        step(2);
        done = 8'h08;
        step(1);
        done = 8'h00;
        chk("t5_rel", 64'(if4.gnt), 64'h00);
        chk("t5_nopulse", 64'(if4.timeout_pulse), 64'h0);
        chk("t5_t0_hold", 64'(if0.gnt), 64'h01);

        step(1);
        chk("t6_pre", 64'(if4.gnt_valid), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async4", 64'(if4.gnt), 64'h0);
        chk("t6_async16", 64'(if16.gnt), 64'h0);
        chk("t6_async0", 64'(if0.gnt), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        req = 8'h80;
        check_all();
        step(1);
        chk("t6_id7", 64'(if4.gnt_id), 64'd7);
        req = 8'h00;
        step(1);
        req = 8'h80;
        step(1);
        chk("t6_lone", 64'(if4.gnt_id), 64'd7);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3) == 0) req = 8'($urandom);
            done = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
            en = ($urandom_range(7) != 0);
            step(1);
        end

        do_reset();
        en = 1'b1;
        req = 8'hFF;
        done = 8'hFF;
        step(511);
        chk("t6_wrap_cnt", 64'(if4.grant_cnt), 64'h0);
        chk("t6_wrap_val", 64'(if4.gnt_valid), 64'h1);
        chk("t6_wrap_seg1", 64'(if4.seg_out[1]), 64'h3F);
        chk("t6_wrap_seg2", 64'(if4.seg_out[2]), 64'h3F);
        chk("t6_wrap_seg7", 64'(if4.seg_out[7]), 64'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
